// File: rtl/coord_tx_scheduler_pkg.sv
// Shared definitions for the coordinate packet link.
//   tx_state_t      : scheduler FSM states
//   coords_t        : the four 12-bit hand coordinates as one frame
//   PAYLOAD_LEN     : payload bytes per packet (fixed)
//   PKT_LEN         : packet length for the default header length
//   pkt_len()       : packet length for an arbitrary header length
//   pack_coord_byte : byte at a given packet index for a coordinate frame
package coord_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_HI,
    WAIT_LO,
    GAP
  } tx_state_t;

  typedef struct packed {
    logic [11:0] xt;
    logic [11:0] yt;
    logic [11:0] xb;
    logic [11:0] yb;
  } coords_t;

  localparam int unsigned SYNC_LEN_DEFAULT = 3;
  localparam int unsigned PAYLOAD_LEN      = 6;
  localparam int unsigned PKT_LEN          = SYNC_LEN_DEFAULT + PAYLOAD_LEN;

  function automatic int unsigned pkt_len(input int unsigned sync_len);
    return sync_len + PAYLOAD_LEN;
  endfunction

  // Header bytes first, then the four coordinates packed big-endian,
  // two 12-bit values sharing the middle byte of each pair.
  function automatic logic [7:0] pack_coord_byte(
    input logic [7:0]  idx,
    input coords_t     c,
    input int unsigned sync_len,
    input logic [7:0]  sync_byte
  );
    int unsigned i;
    logic [7:0]  b;
    i = 32'(idx);
    b = sync_byte;
    if (i >= sync_len) begin
      case (i - sync_len)
        0:       b = c.xt[11:4];
        1:       b = {c.xt[3:0], c.yt[11:8]};
        2:       b = c.yt[7:0];
        3:       b = c.xb[11:4];
        4:       b = {c.xb[3:0], c.yb[11:8]};
        5:       b = c.yb[7:0];
        default: b = '0;
      endcase
    end
    return b;
  endfunction

endpackage

// File: rtl/coord_tx_scheduler_if.sv
// Byte handshake between the packet scheduler and a byte UART transmitter.
//   tx_start : one-cycle start pulse (scheduler -> transmitter)
//   tx_data  : byte to send, valid while tx_start is high
//   tx_busy  : transmitter busy flag (transmitter -> scheduler)
interface coord_tx_scheduler_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;

  modport master (output tx_start, output tx_data, input tx_busy);
  modport slave  (input tx_start, input tx_data, output tx_busy);
endinterface

// File: rtl/coord_tx_scheduler.sv
// Coordinate packet scheduler: frames the four hand coordinates behind a
// sync header and feeds them byte-by-byte to a UART transmitter, with an
// idle gap after each packet and a one-deep "newest wins" pending buffer.
//   clk_65mhz, sys_rst        : clock, synchronous active-high reset
//   enable, xy_update         : update accept gate and one-cycle update pulse
//   hand_{x,y}_{top,bottom}   : 12-bit coordinates sampled on accepted update
//   tx (master)               : tx_start / tx_data / tx_busy byte handshake
//   pkt_busy                  : high whenever not IDLE
//   pkt_sent                  : one-cycle pulse after the last byte completes
//   drop_count                : saturating count of overwritten pending updates
module coord_tx_scheduler
  import coord_link_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE  = 8'hFF,
  parameter int unsigned SYNC_LEN   = 3,
  parameter int unsigned GAP_CYCLES = 1000
) (
  input  logic                  clk_65mhz,
  input  logic                  sys_rst,
  input  logic                  enable,
  input  logic                  xy_update,
  input  logic [11:0]           hand_x_top,
  input  logic [11:0]           hand_y_top,
  input  logic [11:0]           hand_x_bottom,
  input  logic [11:0]           hand_y_bottom,
  coord_tx_scheduler_if.master  tx,
  output logic                  pkt_busy,
  output logic                  pkt_sent,
  output logic [7:0]            drop_count
);

  localparam logic [7:0]  LAST_IDX = 8'(pkt_len(SYNC_LEN) - 1);
  localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);

  tx_state_t   state;
  coords_t     frame;
  coords_t     pend;
  coords_t     in_coords;
  logic        pending;
  logic [7:0]  index;
  logic [31:0] gap_cnt;
  logic        accept;
  logic        gap_done;
  logic        consume;

  always_comb begin
    in_coords = {hand_x_top, hand_y_top, hand_x_bottom, hand_y_bottom};
    accept    = xy_update & enable;
    gap_done  = (state == GAP) && (gap_cnt == GAP_LAST);
    consume   = gap_done & pending;
  end

  always_ff @(posedge clk_65mhz) begin
    if (sys_rst) begin
      state       <= IDLE;
      frame       <= '0;
      pend        <= '0;
      pending     <= 1'b0;
      index       <= '0;
      gap_cnt     <= '0;
      tx.tx_start <= 1'b0;
      tx.tx_data  <= '0;
      pkt_busy    <= 1'b0;
      pkt_sent    <= 1'b0;
      drop_count  <= '0;
    end else begin
      tx.tx_start <= 1'b0;
      pkt_sent    <= 1'b0;

      // tx_start/tx_data are registered, so they are set up on the
      // transition into SEND to land in the SEND cycle itself.
      case (state)
        IDLE: begin
          if (accept) begin
            frame       <= in_coords;
            index       <= '0;
            tx.tx_start <= 1'b1;
            tx.tx_data  <= pack_coord_byte(8'd0, in_coords, SYNC_LEN, SYNC_BYTE);
            pkt_busy    <= 1'b1;
            state       <= SEND;
          end
        end
        SEND: state <= WAIT_HI;
        WAIT_HI: begin
          if (tx.tx_busy) state <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!tx.tx_busy) begin
            if (index == LAST_IDX) begin
              pkt_sent <= 1'b1;
              gap_cnt  <= '0;
              state    <= GAP;
            end else begin
              index       <= index + 8'd1;
              tx.tx_start <= 1'b1;
              tx.tx_data  <= pack_coord_byte(index + 8'd1, frame, SYNC_LEN, SYNC_BYTE);
              state       <= SEND;
            end
          end
        end
        GAP: begin
          if (gap_done) begin
            if (pending) begin
              frame       <= pend;
              pending     <= 1'b0;
              index       <= '0;
              tx.tx_start <= 1'b1;
              tx.tx_data  <= pack_coord_byte(8'd0, pend, SYNC_LEN, SYNC_BYTE);
              state       <= SEND;
            end else begin
              pkt_busy   <= 1'b0;
              tx.tx_data <= '0;
              state      <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase

      // An update landing on the cycle the pending frame is consumed refills
      // the buffer without counting as a drop; the assignment below wins.
      if (accept && (state != IDLE)) begin
        pend    <= in_coords;
        pending <= 1'b1;
        if (pending && !consume && (drop_count != 8'hFF))
          drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_coord_tx_scheduler.sv
module tb_coord_tx_scheduler;
  localparam int unsigned GAP = 20;

  logic        clk_65mhz = 1'b0;
  logic        sys_rst   = 1'b1;
  logic        enable    = 1'b0;
  logic        xy_update = 1'b0;
  logic [11:0] hx_t = '0, hy_t = '0, hx_b = '0, hy_b = '0;
  logic        pkt_busy, pkt_sent;
  logic [7:0]  drop_count;

  coord_tx_scheduler_if tx();

  coord_tx_scheduler #(.SYNC_BYTE(8'hFF), .SYNC_LEN(3), .GAP_CYCLES(GAP)) dut (
    .clk_65mhz    (clk_65mhz),
    .sys_rst      (sys_rst),
    .enable       (enable),
    .xy_update    (xy_update),
    .hand_x_top   (hx_t),
    .hand_y_top   (hy_t),
    .hand_x_bottom(hx_b),
    .hand_y_bottom(hy_b),
    .tx           (tx),
    .pkt_busy     (pkt_busy),
    .pkt_sent     (pkt_sent),
    .drop_count   (drop_count)
  );

  always #5 clk_65mhz = ~clk_65mhz;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_upd    = 0;
  int sent_cnt = 0;
  bit busy_seen = 0;
  bit stall     = 0;
  int busy_cnt  = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         start_q[$];
  int         sent_q[$];

  always @(posedge clk_65mhz) cyc++;

  // Transmitter model: busy rises the cycle after tx_start and stays high 10
  // cycles; while stalled it holds busy low and freezes its countdown.
  always @(posedge clk_65mhz) begin
    if (tx.tx_start) busy_cnt <= 10;
    else if (busy_cnt > 0 && !stall) busy_cnt <= busy_cnt - 1;
  end
  assign tx.tx_busy = !stall && (busy_cnt != 0);

  always @(negedge clk_65mhz) begin
    if (!sys_rst) begin
      if (tx.tx_start) begin obs_q.push_back(tx.tx_data); start_q.push_back(cyc); end
      if (pkt_sent) begin sent_cnt++; sent_q.push_back(cyc); end
      if (pkt_busy) busy_seen = 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void push_pkt(input logic [11:0] a, b, c, d);
    logic [47:0] p;
    p = {a, b, c, d};
    for (int i = 0; i < 3; i++) exp_q.push_back(8'hFF);
    for (int i = 5; i >= 0; i--) exp_q.push_back(p[i*8 +: 8]);
  endfunction

  task automatic clear_sb();
    exp_q.delete(); obs_q.delete(); start_q.delete(); sent_q.delete();
    sent_cnt = 0; busy_seen = 0;
  endtask

  task automatic do_reset();
    @(negedge clk_65mhz);
    sys_rst = 1'b1; xy_update = 1'b0; stall = 0;
    repeat (14) @(negedge clk_65mhz);
    sys_rst = 1'b0;
    clear_sb();
  endtask

  task automatic pulse(input logic [11:0] a, b, c, d);
    @(negedge clk_65mhz);
    hx_t = a; hy_t = b; hx_b = c; hy_b = d;
    xy_update = 1'b1; t_upd = cyc;
    @(negedge clk_65mhz);
    xy_update = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int k;
    repeat (3) @(negedge clk_65mhz);
    for (k = 0; k < max_cyc && pkt_busy; k++) @(negedge clk_65mhz);
    if (pkt_busy) begin
      n_checks++; n_fail++;
      $display("FAIL wait_idle: pkt_busy still 1 after %0d cycles, required 0", max_cyc);
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (3) @(negedge clk_65mhz);
    n_checks++; if (tx.tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b want 0", tx.tx_start); end
    n_checks++; if (tx.tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx.tx_data); end
    n_checks++; if (pkt_busy !== 1'b0) begin n_fail++; $display("FAIL reset_pkt_busy: got %b want 0", pkt_busy); end
    n_checks++; if (pkt_sent !== 1'b0) begin n_fail++; $display("FAIL reset_pkt_sent: got %b want 0", pkt_sent); end
    n_checks++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
    do_reset();
  endtask

  task automatic test_single();
    int n;
    logic [7:0] e, a;
    do_reset();
    enable = 1'b1;
    push_pkt(12'h123, 12'h456, 12'h0AB, 12'h0CD);
    pulse(12'h123, 12'h456, 12'h0AB, 12'h0CD);
    wait_idle(400);
    n_checks++; if (obs_q.size() !== 9) begin n_fail++; $display("FAIL single_len: got %0d bytes want 9", obs_q.size()); end
    n_checks++; if (start_q.size() == 0 || start_q[0] - t_upd !== 1) begin
      n_fail++; $display("FAIL single_latency: got %0d want 1", start_q.size() ? start_q[0] - t_upd : -1);
    end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front(); a = obs_q.size() ? obs_q.pop_front() : 8'hxx;
      n_checks++; if (a !== e) begin n_fail++; $display("FAIL single_byte%0d: got %h want %h", i, a, e); end
    end
    n_checks++; if (sent_cnt !== 1) begin n_fail++; $display("FAIL single_pkt_sent: got %0d want 1", sent_cnt); end
  endtask

  task automatic test_pending();
    int n;
    logic [7:0] e, a;
    do_reset();
    enable = 1'b1;
    push_pkt(12'hA11, 12'hA22, 12'hA33, 12'hA44);
    pulse(12'hA11, 12'hA22, 12'hA33, 12'hA44);
    repeat (30) @(negedge clk_65mhz);
    pulse(12'hB11, 12'hB22, 12'hB33, 12'hB44);
    repeat (30) @(negedge clk_65mhz);
    pulse(12'hC11, 12'hC22, 12'hC33, 12'hC44);
    push_pkt(12'hC11, 12'hC22, 12'hC33, 12'hC44);
    enable = 1'b0;
    hx_t = 12'h777; hy_t = 12'h888;
    n_checks++; if (drop_count !== 8'd1) begin n_fail++; $display("FAIL pending_drop: got %0d want 1", drop_count); end
    wait_idle(1500);
    repeat (GAP + 30) @(negedge clk_65mhz);
    n_checks++; if (obs_q.size() !== 18) begin n_fail++; $display("FAIL pending_len: got %0d bytes want 18", obs_q.size()); end
    n_checks++; if (sent_cnt !== 2) begin n_fail++; $display("FAIL pending_pkts: got %0d want 2", sent_cnt); end
    n_checks++; if (start_q.size() < 10 || sent_q.size() < 1 || start_q[9] - sent_q[0] !== GAP) begin
      n_fail++; $display("FAIL pending_gap: got %0d want %0d",
                         (start_q.size() >= 10 && sent_q.size() >= 1) ? start_q[9] - sent_q[0] : -1, GAP);
    end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front(); a = obs_q.size() ? obs_q.pop_front() : 8'hxx;
      n_checks++; if (a !== e) begin n_fail++; $display("FAIL pending_byte%0d: got %h want %h", i, a, e); end
    end
  endtask

  task automatic test_reset_mid();
    int k, n;
    logic [7:0] e, a;
    do_reset();
    enable = 1'b1;
    pulse(12'h111, 12'h222, 12'h333, 12'h444);
    repeat (10) @(negedge clk_65mhz);
    pulse(12'h555, 12'h666, 12'h777, 12'h888);
    repeat (10) @(negedge clk_65mhz);
    pulse(12'h999, 12'hAAA, 12'hBBB, 12'hCCC);
    for (k = 0; k < 200 && obs_q.size() < 5; k++) @(negedge clk_65mhz);
    n_checks++; if (obs_q.size() !== 5) begin n_fail++; $display("FAIL rstmid_reach5: got %0d bytes want 5", obs_q.size()); end
    repeat (3) @(negedge clk_65mhz);
    sys_rst = 1'b1;
    @(negedge clk_65mhz);
    n_checks++; if (tx.tx_start !== 1'b0) begin n_fail++; $display("FAIL rstmid_tx_start: got %b want 0", tx.tx_start); end
    n_checks++; if (pkt_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_pkt_busy: got %b want 0", pkt_busy); end
    n_checks++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL rstmid_drop: got %0d want 0", drop_count); end
    n_checks++; if (tx.tx_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_tx_data: got %h want 00", tx.tx_data); end
    sys_rst = 1'b0;
    clear_sb();
    repeat (GAP + 20) @(negedge clk_65mhz);
    n_checks++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL rstmid_no_pending: got %0d bytes want 0", obs_q.size()); end
    push_pkt(12'hFED, 12'h012, 12'h3C4, 12'h5A6);
    pulse(12'hFED, 12'h012, 12'h3C4, 12'h5A6);
    wait_idle(400);
    n_checks++; if (obs_q.size() !== 9) begin n_fail++; $display("FAIL rstmid_len: got %0d bytes want 9", obs_q.size()); end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front(); a = obs_q.size() ? obs_q.pop_front() : 8'hxx;
      n_checks++; if (a !== e) begin n_fail++; $display("FAIL rstmid_byte%0d: got %h want %h", i, a, e); end
    end
    n_checks++; if (sent_cnt !== 1) begin n_fail++; $display("FAIL rstmid_pkts: got %0d want 1", sent_cnt); end
  endtask

  task automatic test_disabled();
    do_reset();
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pulse(12'(i * 291), 12'h0F0, 12'h00F, 12'hF00);
      repeat (5) @(negedge clk_65mhz);
    end
    repeat (10) @(negedge clk_65mhz);
    n_checks++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL disabled_tx: got %0d starts want 0", obs_q.size()); end
    n_checks++; if (busy_seen !== 1'b0) begin n_fail++; $display("FAIL disabled_busy: got %b want 0", busy_seen); end
    n_checks++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL disabled_drop: got %0d want 0", drop_count); end
  endtask

  task automatic test_stall();
    int n;
    logic [7:0] e, a;
    do_reset();
    enable = 1'b1;
    stall = 1;
    push_pkt(12'h314, 12'h159, 12'h265, 12'h358);
    pulse(12'h314, 12'h159, 12'h265, 12'h358);
    repeat (50) @(negedge clk_65mhz);
    n_checks++; if (obs_q.size() !== 1) begin n_fail++; $display("FAIL stall_starts: got %0d want 1", obs_q.size()); end
    n_checks++; if (pkt_busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy: got %b want 1", pkt_busy); end
    stall = 0;
    wait_idle(400);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front(); a = obs_q.size() ? obs_q.pop_front() : 8'hxx;
      n_checks++; if (a !== e) begin n_fail++; $display("FAIL stall_byte%0d: got %h want %h", i, a, e); end
    end
    n_checks++; if (sent_cnt !== 1) begin n_fail++; $display("FAIL stall_pkts: got %0d want 1", sent_cnt); end
  endtask

  task automatic test_saturate();
    do_reset();
    enable = 1'b1;
    stall = 1;
    @(negedge clk_65mhz);
    hx_t = 12'h0A0; hy_t = 12'h0B0; hx_b = 12'h0C0; hy_b = 12'h0D0;
    xy_update = 1'b1;
    @(negedge clk_65mhz);
    repeat (101) @(negedge clk_65mhz);
    n_checks++; if (drop_count !== 8'd100) begin n_fail++; $display("FAIL sat_mid: got %0d want 100", drop_count); end
    repeat (200) @(negedge clk_65mhz);
    xy_update = 1'b0;
    n_checks++; if (drop_count !== 8'd255) begin n_fail++; $display("FAIL sat_final: got %0d want 255", drop_count); end
    stall = 0;
    wait_idle(1500);
    n_checks++; if (sent_cnt !== 2) begin n_fail++; $display("FAIL sat_pkts: got %0d want 2", sent_cnt); end
    n_checks++; if (drop_count !== 8'd255) begin n_fail++; $display("FAIL sat_hold: got %0d want 255", drop_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_pending();
    test_reset_mid();
    test_disabled();
    test_stall();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
